wallclock_capture: RTL and testbench

//  Parametrised free-running timestamp base with multi-channel event capture.
//  - Programmable prescaler; wrap pulse; epoch (wrap) counter.
//  - One capture slot per channel, read out through a valid/ready handshake.

---
 rtl/wallclock_capture.sv | 155 +++++++++++++++
 tb/tb_wallclock_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallclock_capture.sv
// -----------------------------------------------------------------------------
// wallclock_capture
//
// Free-running timestamp base with a programmable prescaler, a one-cycle wrap
// pulse and an epoch (wrap) counter.  Each event channel owns one capture slot.
// A rising edge on event_i[c] records the current timestamp into that slot.
// The slot is read out through a valid/ready handshake.
//
// Ports
//   clk_i        clock
//   reset_ni     asynchronous reset, active-low
//   enable_i     1 = timebase counts, 0 = timestamp and prescaler frozen
//   clear_i      synchronous clear of timestamp, prescaler and epoch
//   prescale_i   one tick every prescale_i+1 enabled cycles
//   event_i      per-channel event levels, synchronous to clk_i
//   ts_o         current timestamp
//   wrap_o       one-cycle pulse in the cycle ts_o has just wrapped to 0
//   epoch_o      number of wraps since reset/clear, modulo 2^EPOCH_W
//   cap_valid_o  per-channel: capture slot holds data
//   cap_ts_o     captured timestamps; channel c at [c*TS_WIDTH +: TS_WIDTH]
//   cap_ready_i  per-channel: consumer accepts the slot when valid & ready
//   cap_ovf_o    per-channel sticky flag: an event was dropped
//   ovf_clr_i    per-channel synchronous clear of cap_ovf_o
// -----------------------------------------------------------------------------
module wallclock_capture #(
    parameter int TS_WIDTH   = 16,
    parameter int NUM_CH     = 4,
    parameter int PRESCALE_W = 8,
    parameter int EPOCH_W    = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_ni,
    input  logic                         enable_i,
    input  logic                         clear_i,
    input  logic [PRESCALE_W-1:0]        prescale_i,
    input  logic [NUM_CH-1:0]            event_i,
    output logic [TS_WIDTH-1:0]          ts_o,
    output logic                         wrap_o,
    output logic [EPOCH_W-1:0]           epoch_o,
    output logic [NUM_CH-1:0]            cap_valid_o,
    output logic [NUM_CH*TS_WIDTH-1:0]   cap_ts_o,
    input  logic [NUM_CH-1:0]            cap_ready_i,
    output logic [NUM_CH-1:0]            cap_ovf_o,
    input  logic [NUM_CH-1:0]            ovf_clr_i
);

    logic [PRESCALE_W-1:0]      pre_cnt_q, pre_cnt_d;
    logic [TS_WIDTH-1:0]        ts_q, ts_d;
    logic                       wrap_q, wrap_d;
    logic [EPOCH_W-1:0]         epoch_q, epoch_d;
    logic [NUM_CH-1:0]          event_q, event_d;
    logic [NUM_CH-1:0]          cap_valid_q, cap_valid_d;
    logic [NUM_CH*TS_WIDTH-1:0] cap_ts_q, cap_ts_d;
    logic [NUM_CH-1:0]          cap_ovf_q, cap_ovf_d;

    logic                       tick_s;
    logic [NUM_CH-1:0]          edge_s;
    logic [NUM_CH-1:0]          pop_s;
    logic [NUM_CH-1:0]          load_s;
    logic [NUM_CH-1:0]          drop_s;

    // The >= compare lets a mid-count reduction of prescale_i tick at once
    // instead of running the counter all the way round.
    assign tick_s = enable_i && (pre_cnt_q >= prescale_i);

    // A slot may be refilled in the same cycle it is being drained.
    assign edge_s = event_i & ~event_q;
    assign pop_s  = cap_valid_q & cap_ready_i;
    assign load_s = edge_s & (~cap_valid_q | pop_s);
    assign drop_s = edge_s & ~load_s;

    // Timebase next state: clear beats tick, tick beats plain prescaler count.
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        ts_d      = ts_q;
        wrap_d    = 1'b0;
        epoch_d   = epoch_q;
        if (clear_i) begin
            pre_cnt_d = {PRESCALE_W{1'b0}};
            ts_d      = {TS_WIDTH{1'b0}};
            epoch_d   = {EPOCH_W{1'b0}};
        end else if (tick_s) begin
            pre_cnt_d = {PRESCALE_W{1'b0}};
            ts_d      = ts_q + TS_WIDTH'(1);
            if (ts_q == {TS_WIDTH{1'b1}}) begin
                wrap_d  = 1'b1;
                epoch_d = epoch_q + EPOCH_W'(1);
            end else begin
                wrap_d  = 1'b0;
            end
        end else if (enable_i) begin
            pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
        end else begin
            pre_cnt_d = pre_cnt_q;
        end
    end

    // Capture slots next state; captures use the pre-increment timestamp.
    always_comb begin
        event_d     = event_i;
        cap_valid_d = cap_valid_q;
        cap_ts_d    = cap_ts_q;
        cap_ovf_d   = cap_ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (load_s[c]) begin
                cap_valid_d[c]                    = 1'b1;
                cap_ts_d[c*TS_WIDTH +: TS_WIDTH]  = ts_q;
            end else if (pop_s[c]) begin
                cap_valid_d[c] = 1'b0;
            end else begin
                cap_valid_d[c] = cap_valid_q[c];
            end
            // A drop in the same cycle as a clear request keeps the flag set.
            if (drop_s[c]) begin
                cap_ovf_d[c] = 1'b1;
            end else if (ovf_clr_i[c]) begin
                cap_ovf_d[c] = 1'b0;
            end else begin
                cap_ovf_d[c] = cap_ovf_q[c];
            end
        end
    end

    // State registers; event history resets to 0 so a level held through
    // reset release is seen as a rising edge on the first clock.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pre_cnt_q   <= {PRESCALE_W{1'b0}};
            ts_q        <= {TS_WIDTH{1'b0}};
            wrap_q      <= 1'b0;
            epoch_q     <= {EPOCH_W{1'b0}};
            event_q     <= {NUM_CH{1'b0}};
            cap_valid_q <= {NUM_CH{1'b0}};
            cap_ts_q    <= {(NUM_CH*TS_WIDTH){1'b0}};
            cap_ovf_q   <= {NUM_CH{1'b0}};
        end else begin
            pre_cnt_q   <= pre_cnt_d;
            ts_q        <= ts_d;
            wrap_q      <= wrap_d;
            epoch_q     <= epoch_d;
            event_q     <= event_d;
            cap_valid_q <= cap_valid_d;
            cap_ts_q    <= cap_ts_d;
            cap_ovf_q   <= cap_ovf_d;
        end
    end

    assign ts_o        = ts_q;
    assign wrap_o      = wrap_q;
    assign epoch_o     = epoch_q;
    assign cap_valid_o = cap_valid_q;
    assign cap_ts_o    = cap_ts_q;
    assign cap_ovf_o   = cap_ovf_q;

endmodule

// File: tb/tb_wallclock_capture.sv
// -----------------------------------------------------------------------------
// tb_wallclock_capture
//
// Directed bench for wallclock_capture with default parameters.  Prescaler
// behaviour is driven from a vector table; wrap, capture, clear and reset
// corner cases are hand-written sequences.  Inputs change 1 ns after the
// rising edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_wallclock_capture;

    localparam int TSW = 16;
    localparam int NCH = 4;
    localparam int PSW = 8;
    localparam int EPW = 8;

    logic             clk_i;
    logic             reset_ni;
    logic             enable_i;
    logic             clear_i;
    logic [PSW-1:0]   prescale_i;
    logic [NCH-1:0]   event_i;
    logic [TSW-1:0]   ts_o;
    logic             wrap_o;
    logic [EPW-1:0]   epoch_o;
    logic [NCH-1:0]   cap_valid_o;
    logic [NCH*TSW-1:0] cap_ts_o;
    logic [NCH-1:0]   cap_ready_i;
    logic [NCH-1:0]   cap_ovf_o;
    logic [NCH-1:0]   ovf_clr_i;

    int total = 0;
    int bad   = 0;

    wallclock_capture #(
        .TS_WIDTH   (TSW),
        .NUM_CH     (NCH),
        .PRESCALE_W (PSW),
        .EPOCH_W    (EPW)
    ) dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .enable_i    (enable_i),
        .clear_i     (clear_i),
        .prescale_i  (prescale_i),
        .event_i     (event_i),
        .ts_o        (ts_o),
        .wrap_o      (wrap_o),
        .epoch_o     (epoch_o),
        .cap_valid_o (cap_valid_o),
        .cap_ts_o    (cap_ts_o),
        .cap_ready_i (cap_ready_i),
        .cap_ovf_o   (cap_ovf_o),
        .ovf_clr_i   (ovf_clr_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic           en;
        logic           clr;
        logic [PSW-1:0] pre;
        logic [TSW-1:0] exp_ts;
        logic           exp_wrap;
    } vec_t;

    // Starts right after a clear (ts=0, prescaler count=0).
    // Rows 1-11: prescale 3 -> tick every 4th cycle; after row 11 count is 3.
    // Row 12 drops prescale to 1: immediate tick, then every 2 cycles.
    // Row 17 freezes the timebase; row 20 clears.
    vec_t tbl [20] = '{
        '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0000, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0001, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0001, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0001, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0001, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0002, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0002, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0002, 1'b0},
        '{1'b1, 1'b0, 8'd3, 16'h0002, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0003, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0003, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0004, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0004, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0005, 1'b0},
        '{1'b0, 1'b0, 8'd1, 16'h0005, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0005, 1'b0},
        '{1'b1, 1'b0, 8'd1, 16'h0006, 1'b0},
        '{1'b1, 1'b1, 8'd1, 16'h0000, 1'b0}
    };

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [TSW-1:0] cap(input int c);
        return cap_ts_o[c*TSW +: TSW];
    endfunction

    initial begin
        int wraps;
        reset_ni    = 1'b0;
        enable_i    = 1'b0;
        clear_i     = 1'b0;
        prescale_i  = 8'd0;
        event_i     = 4'd0;
        cap_ready_i = 4'd0;
        ovf_clr_i   = 4'd0;

        // Reset state
        #12;
        chk("rst_ts",    ts_o,        16'h0000);
        chk("rst_wrap",  wrap_o,      1'b0);
        chk("rst_epoch", epoch_o,     8'd0);
        chk("rst_valid", cap_valid_o, 4'd0);
        chk("rst_capts", cap_ts_o,    64'd0);
        chk("rst_ovf",   cap_ovf_o,   4'd0);
        @(negedge clk_i);
        reset_ni = 1'b1;
        enable_i = 1'b1;

        // Full wrap with prescale 0: one step per cycle, single wrap pulse
        wraps = 0;
        for (int i = 1; i <= 65538; i++) begin
            step();
            if (ts_o !== 16'((i % 65536))) chk("t1_ts", ts_o, 16'((i % 65536)));
            else total++;
            if (wrap_o !== (i == 65536)) chk("t1_wrap", wrap_o, (i == 65536));
            else total++;
            if (wrap_o === 1'b1) wraps++;
        end
        chk("t1_wrap_count", wraps, 1);
        chk("t1_epoch", epoch_o, 8'd1);
        chk("t1_ts_end", ts_o, 16'h0002);

        // Clear with a valid slot: fill ch2 at ts=2, count up to 0x1234
        event_i = 4'b0100;
        step();
        chk("t5_cap2", cap(2), 16'h0002);
        chk("t5_valid2", cap_valid_o[2], 1'b1);
        event_i = 4'b0000;
        for (int i = 0; i < 16'h1231; i++) step();
        chk("t5_ts_pre", ts_o, 16'h1234);
        chk("t5_epoch_pre", epoch_o, 8'd1);
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        chk("t5_ts", ts_o, 16'h0000);
        chk("t5_epoch", epoch_o, 8'd0);
        chk("t5_wrap", wrap_o, 1'b0);
        chk("t5_valid2_kept", cap_valid_o[2], 1'b1);
        chk("t5_cap2_kept", cap(2), 16'h0002);

        // Prescaler vector table
        for (int k = 0; k < 20; k++) begin
            enable_i   = tbl[k].en;
            clear_i    = tbl[k].clr;
            prescale_i = tbl[k].pre;
            step();
            chk($sformatf("t2_ts_row%0d", k + 1), ts_o, tbl[k].exp_ts);
            chk($sformatf("t2_wrap_row%0d", k + 1), wrap_o, tbl[k].exp_wrap);
        end
        enable_i   = 1'b1;
        clear_i    = 1'b0;
        prescale_i = 8'd0;

        // Capture on ch0 at ts=0x10, then overflow while held
        for (int i = 0; i < 16; i++) step();
        chk("t3_ts_at_edge", ts_o, 16'h0010);
        event_i = 4'b0001;
        step();
        chk("t3_valid0", cap_valid_o[0], 1'b1);
        chk("t3_cap0", cap(0), 16'h0010);
        chk("t3_ts_after", ts_o, 16'h0011);
        event_i = 4'b0000;
        step();
        event_i = 4'b0001;
        step();
        chk("t3_ovf0", cap_ovf_o[0], 1'b1);
        chk("t3_cap0_held", cap(0), 16'h0010);
        chk("t3_valid0_held", cap_valid_o[0], 1'b1);
        event_i = 4'b0000;
        step();
        event_i   = 4'b0001;
        ovf_clr_i = 4'b0001;
        step();
        chk("t3_ovf_drop_wins", cap_ovf_o[0], 1'b1);
        event_i = 4'b0000;
        step();
        ovf_clr_i = 4'b0000;
        chk("t3_ovf_cleared", cap_ovf_o[0], 1'b0);
        cap_ready_i = 4'b0001;
        step();
        cap_ready_i = 4'b0000;
        chk("t3_pop0", cap_valid_o[0], 1'b0);
        chk("t3_cap0_final", cap(0), 16'h0010);

        // Simultaneous pop and new edge on ch1 at ts=0x20
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        event_i = 4'b0010;
        step();
        chk("t4_valid1", cap_valid_o[1], 1'b1);
        chk("t4_cap1_first", cap(1), 16'h0000);
        event_i = 4'b0000;
        for (int i = 0; i < 31; i++) step();
        chk("t4_ts_at_edge", ts_o, 16'h0020);
        event_i     = 4'b0010;
        cap_ready_i = 4'b0010;
        step();
        chk("t4_valid1_kept", cap_valid_o[1], 1'b1);
        chk("t4_cap1_new", cap(1), 16'h0020);
        chk("t4_no_ovf", cap_ovf_o[1], 1'b0);
        step();
        cap_ready_i = 4'b0000;
        chk("t4_pop1", cap_valid_o[1], 1'b0);
        event_i = 4'b0000;

        // Reset mid-operation with slots valid and overflow set
        event_i = 4'b1000;
        step();
        event_i = 4'b0000;
        step();
        event_i = 4'b1000;
        step();
        chk("t6_ovf3_pre", cap_ovf_o[3], 1'b1);
        chk("t6_valid_pre", cap_valid_o, 4'b1100);
        #2;
        reset_ni = 1'b0;
        #1;
        chk("t6_ts", ts_o, 16'h0000);
        chk("t6_epoch", epoch_o, 8'd0);
        chk("t6_wrap", wrap_o, 1'b0);
        chk("t6_valid", cap_valid_o, 4'd0);
        chk("t6_capts", cap_ts_o, 64'd0);
        chk("t6_ovf", cap_ovf_o, 4'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;
        step();
        chk("t6_rel_valid", cap_valid_o, 4'b1000);
        chk("t6_rel_cap3", cap(3), 16'h0000);
        chk("t6_rel_ts", ts_o, 16'h0001);
        step();
        chk("t6_no_reedge", cap_valid_o, 4'b1000);
        chk("t6_no_ovf", cap_ovf_o, 4'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
